// File: rtl/ssd1331_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ssd1331_pkg                                                      |
// | Shared state encoding, default sizes and port indices for the    |
// | SSD1331 SPI transmit arbiter.                                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ssd1331_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 8;
  localparam int NTX_W     = 5;

  localparam logic PORT_INIT = 1'b0;
  localparam logic PORT_DRAW = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ssd1331_rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ssd1331_rr_arb2                                                  |
// | Two-input round-robin / fixed-priority arbiter; the priority     |
// | pointer moves only when the top accepts a finished grant.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ssd1331_rr_arb2
  import ssd1331_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  input  logic       i_accept_port,
  output logic [1:0] o_gnt
);

  // Last granted port; reset value leaves port 0 with priority.
  logic r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT_DRAW;
    end else if (i_accept) begin
      r_last <= i_accept_port;
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = ((ROUND_ROBIN != 0) && (r_last == PORT_INIT)) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ssd1331_spi_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ssd1331_spi_tx_arbiter                                           |
// | Shares one SPI transmit buffer between the init sequencer and    |
// | the draw engine: latch, start, wait, gap, then done/error.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ssd1331_spi_tx_arbiter
  import ssd1331_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int N           = DEF_N,
  parameter int GAP_CYCLES  = 4,
  parameter int TIMEOUT     = 1024,
  parameter int ROUND_ROBIN = 1
) (
  input  logic               i_SCK,
  input  logic               i_RST,
  input  logic [1:0]         i_REQ,
  input  logic [WIDTH*N-1:0] i_DATA0,
  input  logic [WIDTH*N-1:0] i_DATA1,
  input  logic [N-1:0]       i_DC0,
  input  logic [N-1:0]       i_DC1,
  input  logic [NTX_W-1:0]   i_NTX0,
  input  logic [NTX_W-1:0]   i_NTX1,
  output logic [1:0]         o_GNT,
  output logic [1:0]         o_DONE,
  output logic [1:0]         o_ERR,
  output logic [WIDTH*N-1:0] o_DATA,
  output logic [N-1:0]       o_DC,
  output logic [NTX_W-1:0]   o_N_transmit,
  output logic               o_START,
  input  logic               i_MOSI_FINAL_TX,
  output logic               o_BUSY
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [NTX_W-1:0] c_N_MAX    = NTX_W'(N);
  localparam logic [TO_W-1:0]  c_TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_gnt;
  logic [1:0]         r_done;
  logic [1:0]         r_err;
  logic [WIDTH*N-1:0] r_data;
  logic [N-1:0]       r_dc;
  logic [NTX_W-1:0]   r_ntx;
  logic               r_start;
  logic               r_busy;
  logic [TO_W-1:0]    r_to_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;

  logic [1:0] w_arb_gnt;
  logic       w_latch;
  logic       w_finish;
  logic       w_fault;
  logic       w_accept;
  logic       w_count_bad;

  ssd1331_rr_arb2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .clk           (i_SCK),
    .rst_n         (i_RST),
    .i_req         (i_REQ),
    .i_accept      (w_accept),
    .i_accept_port (r_gnt[1]),
    .o_gnt         (w_arb_gnt)
  );

  assign w_count_bad = (r_ntx == '0) || (r_ntx > c_N_MAX);

  always_ff @(posedge i_SCK or negedge i_RST) begin
    if (!i_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_finish    = 1'b0;
    w_fault     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_REQ) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_count_bad) begin
          w_finish    = 1'b1;
          w_fault     = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_BUSY;
      ST_BUSY: begin
        // Completion takes precedence over a coincident timeout.
        if (i_MOSI_FINAL_TX) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_finish    = 1'b1;
          w_fault     = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_SCK or negedge i_RST) begin
    if (!i_RST) begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_data    <= '0;
      r_dc      <= '0;
      r_ntx     <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_start   <= (w_state_nxt == ST_START);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_finish ? r_gnt : 2'b00;
      r_err     <= w_fault  ? r_gnt : 2'b00;
      r_to_cnt  <= (r_state == ST_BUSY) ? r_to_cnt + 1'b1 : '0;
      r_gap_cnt <= (r_state == ST_GAP)  ? r_gap_cnt + 1'b1 : '0;
      if (w_latch) begin
        r_gnt  <= w_arb_gnt;
        r_data <= w_arb_gnt[1] ? i_DATA1 : i_DATA0;
        r_dc   <= w_arb_gnt[1] ? i_DC1   : i_DC0;
        r_ntx  <= w_arb_gnt[1] ? i_NTX1  : i_NTX0;
      end else if (w_accept) begin
        r_gnt <= '0;
      end
    end
  end

  assign o_GNT        = r_gnt;
  assign o_DONE       = r_done;
  assign o_ERR        = r_err;
  assign o_DATA       = r_data;
  assign o_DC         = r_dc;
  assign o_N_transmit = r_ntx;
  assign o_START      = r_start;
  assign o_BUSY       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ssd1331_spi_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ssd1331_spi_tx_arbiter                                        |
// | Directed self-checking bench: round-robin and fixed-priority     |
// | instances sharing stimulus, separate request lines.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ssd1331_spi_tx_arbiter;

  localparam int W   = 8;
  localparam int NB  = 8;
  localparam int GAP = 4;
  localparam int TO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      req_rr = '0;
  logic [1:0]      req_fp = '0;
  logic [W*NB-1:0] data0  = '0;
  logic [W*NB-1:0] data1  = '0;
  logic [NB-1:0]   dc0    = '0;
  logic [NB-1:0]   dc1    = '0;
  logic [4:0]      ntx0   = '0;
  logic [4:0]      ntx1   = '0;
  logic            final_tx = 1'b0;
  logic            sel_fp   = 1'b0;

  logic [1:0]      rr_gnt, rr_done, rr_err, fp_gnt, fp_done, fp_err;
  logic [W*NB-1:0] rr_data, fp_data;
  logic [NB-1:0]   rr_dc, fp_dc;
  logic [4:0]      rr_ntx, fp_ntx;
  logic            rr_start, rr_busy, fp_start, fp_busy;

  ssd1331_spi_tx_arbiter #(.WIDTH(W), .N(NB), .GAP_CYCLES(GAP), .TIMEOUT(TO), .ROUND_ROBIN(1)) dut_rr (
    .i_SCK(clk), .i_RST(rst_n), .i_REQ(req_rr),
    .i_DATA0(data0), .i_DATA1(data1), .i_DC0(dc0), .i_DC1(dc1), .i_NTX0(ntx0), .i_NTX1(ntx1),
    .o_GNT(rr_gnt), .o_DONE(rr_done), .o_ERR(rr_err), .o_DATA(rr_data), .o_DC(rr_dc),
    .o_N_transmit(rr_ntx), .o_START(rr_start), .i_MOSI_FINAL_TX(final_tx), .o_BUSY(rr_busy)
  );

  ssd1331_spi_tx_arbiter #(.WIDTH(W), .N(NB), .GAP_CYCLES(GAP), .TIMEOUT(TO), .ROUND_ROBIN(0)) dut_fp (
    .i_SCK(clk), .i_RST(rst_n), .i_REQ(req_fp),
    .i_DATA0(data0), .i_DATA1(data1), .i_DC0(dc0), .i_DC1(dc1), .i_NTX0(ntx0), .i_NTX1(ntx1),
    .o_GNT(fp_gnt), .o_DONE(fp_done), .o_ERR(fp_err), .o_DATA(fp_data), .o_DC(fp_dc),
    .o_N_transmit(fp_ntx), .o_START(fp_start), .i_MOSI_FINAL_TX(final_tx), .o_BUSY(fp_busy)
  );

  logic [1:0] obs_gnt, obs_done, obs_err;
  logic       obs_start, obs_busy;
  always_comb begin
    obs_gnt   = sel_fp ? fp_gnt   : rr_gnt;
    obs_done  = sel_fp ? fp_done  : rr_done;
    obs_err   = sel_fp ? fp_err   : rr_err;
    obs_start = sel_fp ? fp_start : rr_start;
    obs_busy  = sel_fp ? fp_busy  : rr_busy;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int last_start;
  logic start_seen;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  // Wait for START, complete the transfer with one final-TX pulse, check the done pulse.
  task automatic txn(input logic [1:0] exp_gnt, input string tag);
    for (int k = 0; k < 30 && !obs_start; k++) tick();
    check({tag, "_start"}, obs_start, 1'b1);
    check({tag, "_gnt"}, obs_gnt, exp_gnt);
    last_start = cyc;
    tick();
    final_tx = 1'b1;
    tick();
    final_tx = 1'b0;
    check({tag, "_done"}, obs_done, exp_gnt);
    check({tag, "_err"}, obs_err, 2'b00);
  endtask

  task automatic wait_idle(input string tag);
    start_seen = 1'b0;
    for (int k = 0; k < 30 && obs_busy; k++) begin
      tick();
      start_seen = start_seen | obs_start;
    end
    check({tag, "_idle"}, obs_busy, 1'b0);
    check({tag, "_gnt_clr"}, obs_gnt, 2'b00);
  endtask

  initial begin
    int prev;
    data0 = 64'h0000_0000_0804_0201;
    data1 = 64'h0000_0000_00CC_BBAA;
    dc0   = 8'h05;
    dc1   = 8'h01;
    ntx0  = 5'd4;
    ntx1  = 5'd3;

    // Reset state
    do_reset();
    check("rst_gnt", rr_gnt, 2'b00);
    check("rst_busy", rr_busy, 1'b0);
    check("rst_start", rr_start, 1'b0);
    check("rst_done", rr_done, 2'b00);
    check("rst_ntx", rr_ntx, 5'd0);

    // Final-TX outside BUSY is ignored
    final_tx = 1'b1;
    tick();
    final_tx = 1'b0;
    check("idle_ftx_busy", rr_busy, 1'b0);
    check("idle_ftx_done", rr_done, 2'b00);

    // Single request on port 0
    req_rr = 2'b01;
    tick();
    check("t1_load_gnt", rr_gnt, 2'b01);
    check("t1_load_start", rr_start, 1'b0);
    check("t1_load_busy", rr_busy, 1'b1);
    check("t1_ntx", rr_ntx, 5'd4);
    tick();
    check("t1_start", rr_start, 1'b1);
    check("t1_data", rr_data, 64'h0000_0000_0804_0201);
    check("t1_dc", rr_dc, 8'h05);
    tick();
    check("t1_start_1cyc", rr_start, 1'b0);
    final_tx = 1'b1;
    tick();
    final_tx = 1'b0;
    req_rr   = 2'b00;
    check("t1_done", rr_done, 2'b01);
    check("t1_err", rr_err, 2'b00);
    tick();
    check("t1_done_pulse", rr_done, 2'b00);
    repeat (2) tick();
    check("t1_gap_gnt_held", rr_gnt, 2'b01);
    tick();
    check("t1_gap_exit_busy", rr_busy, 1'b0);
    check("t1_gap_exit_gnt", rr_gnt, 2'b00);

    // Round-robin with both held
    do_reset();
    req_rr = 2'b11;
    for (int i = 0; i < 4; i++) begin
      prev = last_start;
      txn((i % 2 == 0) ? 2'b01 : 2'b10, "rr");
      if (i > 0) check("rr_spacing", (last_start - prev) >= GAP + 2, 1'b1);
    end
    req_rr = 2'b00;
    wait_idle("rr");

    // Fixed priority: port 0 wins while requesting
    sel_fp = 1'b1;
    req_fp = 2'b11;
    for (int i = 0; i < 3; i++) txn(2'b01, "fp");
    req_fp = 2'b10;
    txn(2'b10, "fp_p1");
    req_fp = 2'b00;
    wait_idle("fp");
    sel_fp = 1'b0;

    // Illegal counts on port 1
    for (int j = 0; j < 2; j++) begin
      ntx1   = (j == 0) ? 5'd0 : 5'd9;
      req_rr = 2'b10;
      tick();
      check("bad_load_gnt", rr_gnt, 2'b10);
      check("bad_ntx", rr_ntx, (j == 0) ? 5'd0 : 5'd9);
      tick();
      req_rr = 2'b00;
      check("bad_done", rr_done, 2'b10);
      check("bad_err", rr_err, 2'b10);
      check("bad_nostart", rr_start, 1'b0);
      wait_idle("bad");
      check("bad_nostart_gap", start_seen, 1'b0);
    end
    ntx1 = 5'd3;

    // Timeout with no completion
    req_rr = 2'b01;
    txn(2'b01, "pre_to");
    req_rr = 2'b00;
    wait_idle("pre_to");
    req_rr = 2'b01;
    for (int k = 0; k < 30 && !rr_start; k++) tick();
    check("to_start", rr_start, 1'b1);
    repeat (16) tick();
    check("to_not_yet", rr_done, 2'b00);
    tick();
    req_rr = 2'b00;
    check("to_done", rr_done, 2'b01);
    check("to_err", rr_err, 2'b01);
    wait_idle("to");

    // Completion on the 16th BUSY cycle beats the timeout
    req_rr = 2'b01;
    for (int k = 0; k < 30 && !rr_start; k++) tick();
    check("tc_start", rr_start, 1'b1);
    repeat (16) tick();
    final_tx = 1'b1;
    tick();
    final_tx = 1'b0;
    req_rr   = 2'b00;
    check("tc_done", rr_done, 2'b01);
    check("tc_noerr", rr_err, 2'b00);
    wait_idle("tc");

    // Reset while BUSY
    req_rr = 2'b10;
    for (int k = 0; k < 30 && !rr_start; k++) tick();
    check("rb_start", rr_start, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rb_gnt", rr_gnt, 2'b00);
    check("rb_start_low", rr_start, 1'b0);
    check("rb_busy", rr_busy, 1'b0);
    check("rb_done", rr_done, 2'b00);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("rb_no_done", rr_done, 2'b00);
    txn(2'b10, "rb_regrant");
    req_rr = 2'b00;
    wait_idle("rb");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ssd1331_spi_tx_arbiter.md
Name: ssd1331_spi_tx_arbiter

Overview:
- Shares one Nbit_MOSI_SPI_Buffer + Nbit_MOSI_SPI transmit path between two requesters: port 0 (init/config command sequencer) and port 1 (pixel/draw engine).
- Latches the winning requester's packed bytes, D/C mask and byte count, then pulses the buffer start.
- Waits for SPI completion, enforces a minimum inter-transaction gap, then returns a done/error pulse to the granted requester.

Parameters:
- WIDTH, 8, bits per SPI word
- N, 8, max bytes per transaction (≤ 31, fits 5-bit count)
- GAP_CYCLES, 4, idle SCK cycles between transactions (≥ 1)
- TIMEOUT, 1024, max SCK cycles in BUSY before abort
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = port 0 fixed priority

Ports:
- i_SCK  in  1  clock, shared with the SPI path
- i_RST  in  1  asynchronous reset, active-low
- i_REQ  in  2  per-port request, level; bit0 = port 0
- i_DATA0 / i_DATA1  in  WIDTH*N  packed bytes; byte0 in [WIDTH-1:0] is transmitted first
- i_DC0 / i_DC1  in  N  per-byte D/C bit
- i_NTX0 / i_NTX1  in  5  bytes to send
- o_GNT  out  2  one-hot grant, held from latch through GAP
- o_DONE  out  2  one-cycle completion pulse, granted port only
- o_ERR  out  2  one-cycle, coincident with o_DONE, on reject or timeout
- o_DATA  out  WIDTH*N  to buffer i_DATA
- o_DC  out  N  to buffer i_DC
- o_N_transmit  out  5  to buffer i_N_transmit
- o_START  out  1  to buffer i_START
- i_MOSI_FINAL_TX  in  1  completion pulse from Nbit_MOSI_SPI
- o_BUSY  out  1  high in any state except IDLE

Behaviour:
- Reset (async, i_RST=0) clears all outputs and registers to 0 and forces state IDLE. The round-robin pointer resets to port 0 having priority. Reset mid-transaction aborts without a DONE pulse; o_START is low in the same cycle.
- States: IDLE, LOAD, START, BUSY, GAP.
- IDLE: evaluate i_REQ on each rising edge.
  - ROUND_ROBIN=1: on a tie, the port not most recently granted wins.
  - ROUND_ROBIN=0: port 0 always wins a tie.
  - The winner's data, D/C mask and count are latched into o_DATA/o_DC/o_N_transmit, o_GNT is set, and the next state is LOAD.
- Reject: a latched count of 0 or greater than N goes LOAD -> GAP with o_DONE and o_ERR pulsed; o_START never asserts.
- LOAD: one cycle so the latched operands are stable. Valid count -> START.
- START: o_START=1 for exactly one cycle, then BUSY. Latched outputs stay constant until GAP exits.
- BUSY:
  - The timeout counter starts at 0 and increments each cycle.
  - i_MOSI_FINAL_TX=1 -> o_DONE pulse, go to GAP.
  - Counter reaching TIMEOUT-1 without completion -> o_DONE and o_ERR pulse, go to GAP.
  - If completion and timeout occur on the same cycle, completion wins (no ERR).
- GAP: hold for GAP_CYCLES cycles with o_GNT still asserted, then clear o_GNT, update the round-robin pointer and return to IDLE.
  - A request still asserted at IDLE is re-arbitrated normally, so back-to-back transactions are spaced by at least GAP_CYCLES+2 cycles.
- Requests:
  - i_REQ deassertion after latch is ignored; the transaction is committed.
  - Requester inputs are sampled only in IDLE.
  - Requesters keep i_REQ high until o_DONE and must drop it the cycle after o_DONE to avoid a repeat.
- i_MOSI_FINAL_TX outside BUSY is ignored.
- Latency: request seen in IDLE -> o_START asserted 2 cycles later.

Decomposition:
- Shared package ssd1331_pkg: state encoding constants (IDLE..GAP), WIDTH/N defaults, and the port index constants PORT_INIT=0, PORT_DRAW=1.
- One natural sub-module: ssd1331_rr_arb2, a 2-input round-robin/fixed-priority arbiter with a grant-accept update. The FSM, counters and operand latch remain in the top module.

Test Plan:
- Single request: port 0, NTX0=4, DATA bytes 0x01/0x02/0x04/0x08, DC0=0x05 -> o_GNT=01 and o_START high 2 cycles after request; o_N_transmit=4; o_DONE[0] one cycle after a driven i_MOSI_FINAL_TX; o_ERR=0.
- Simultaneous requests, ROUND_ROBIN=1, both held -> grants alternate 01,10,01,10. Successive o_START pulses are ≥ GAP_CYCLES+2 apart.
- ROUND_ROBIN=0, both held -> port 0 wins every arbitration while requesting. Port 1 is granted only after port 0 drops REQ.
- Illegal count: NTX1=0, then NTX1=9 with N=8 -> o_START never asserts; o_DONE[1] and o_ERR[1] pulse together; arbiter returns to IDLE after GAP.
- Timeout, TIMEOUT=16: i_MOSI_FINAL_TX never asserts -> o_DONE and o_ERR pulse after 16 BUSY cycles. A final-TX pulse coinciding with the 16th cycle -> DONE without ERR.
- Reset in BUSY: i_RST low mid-transaction -> o_GNT, o_START, o_BUSY drop asynchronously with no o_DONE. After release, a pending request is re-granted.
